// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer
//   Control FSM that walks the shared MAC + CORDIC activation datapath through
//   a full forward pass. The run configuration is latched on an accepted
//   start. The sequencer then issues one MAC command per weight and one
//   activation command per neuron, and generates the weight and data-buffer
//   addresses for each command.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   start                run request, sampled only while idle
//   no_layers            number of layers to run (1..5)
//   nl1..nl5             neurons per layer
//   afl1..afl5           activation code per layer
//   busy / done / err    status: not idle / end-of-run pulse / sticky config error
//   mac_*                MAC command channel (valid/ready, first/last, w_addr, x_addr)
//   act_*                activation command channel (valid/ready, act_func, y_addr)
//   layer_idx            current layer, 0-based
module nn_layer_sequencer #(
  parameter int N_INPUTS = 2,
  parameter int WADDR_W  = 15,
  parameter int DADDR_W  = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [5:0]         no_layers,
  input  logic [5:0]         nl1,
  input  logic [5:0]         nl2,
  input  logic [5:0]         nl3,
  input  logic [5:0]         nl4,
  input  logic [5:0]         nl5,
  input  logic [1:0]         afl1,
  input  logic [1:0]         afl2,
  input  logic [1:0]         afl3,
  input  logic [1:0]         afl4,
  input  logic [1:0]         afl5,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               mac_valid,
  input  logic               mac_ready,
  output logic               mac_first,
  output logic               mac_last,
  output logic [WADDR_W-1:0] w_addr,
  output logic [DADDR_W-1:0] x_addr,
  output logic               act_valid,
  input  logic               act_ready,
  output logic [1:0]         act_func,
  output logic [DADDR_W-1:0] y_addr,
  output logic [2:0]         layer_idx
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MAC, S_ACT, S_DONE} state_t;

  state_t             state;
  logic [5:0]         nlayers;
  logic [5:0]         nl_q  [5];
  logic [1:0]         afl_q [5];
  logic [5:0]         i_cnt;
  logic [5:0]         j_cnt;
  logic [DADDR_W-1:0] in_base;
  logic [DADDR_W-1:0] out_base;
  logic [5:0]         fan_in;
  logic [5:0]         cur_nl;
  logic               cfg_bad;

  // Layer 0 reads the network inputs; later layers read the previous layer.
  always_comb begin
    if (layer_idx == 3'd0) fan_in = 6'(N_INPUTS);
    else                   fan_in = nl_q[layer_idx - 3'd1];
  end

  assign cur_nl = nl_q[layer_idx];

  always_comb begin
    cfg_bad = (nlayers == 6'd0) || (nlayers > 6'd5);
    for (int unsigned k = 0; k < 5; k++) begin
      if ((6'(k) < nlayers) && (nl_q[k] == 6'd0)) cfg_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mac_valid <= 1'b0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
      w_addr    <= '0;
      x_addr    <= '0;
      act_valid <= 1'b0;
      act_func  <= '0;
      y_addr    <= '0;
      layer_idx <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      in_base   <= '0;
      out_base  <= '0;
      nlayers   <= '0;
      for (int unsigned k = 0; k < 5; k++) begin
        nl_q[k]  <= '0;
        afl_q[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_CHECK;
            busy     <= 1'b1;
            err      <= 1'b0;
            nlayers  <= no_layers;
            nl_q[0]  <= nl1;
            nl_q[1]  <= nl2;
            nl_q[2]  <= nl3;
            nl_q[3]  <= nl4;
            nl_q[4]  <= nl5;
            afl_q[0] <= afl1;
            afl_q[1] <= afl2;
            afl_q[2] <= afl3;
            afl_q[3] <= afl4;
            afl_q[4] <= afl5;
          end
        end

        S_CHECK: begin
          if (cfg_bad) begin
            state <= S_DONE;
            err   <= 1'b1;
            done  <= 1'b1;
          end else begin
            state     <= S_MAC;
            layer_idx <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            w_addr    <= '0;
            in_base   <= '0;
            out_base  <= DADDR_W'(N_INPUTS);
            mac_valid <= 1'b1;
            x_addr    <= '0;
            mac_first <= 1'b1;
            mac_last  <= (N_INPUTS == 1);
          end
        end

        S_MAC: begin
          if (mac_ready) begin
            w_addr <= w_addr + WADDR_W'(1);
            if (mac_last) begin
              state     <= S_ACT;
              mac_valid <= 1'b0;
              mac_first <= 1'b0;
              mac_last  <= 1'b0;
              act_valid <= 1'b1;
              act_func  <= afl_q[layer_idx];
              y_addr    <= out_base + DADDR_W'(j_cnt);
            end else begin
              i_cnt     <= i_cnt + 6'd1;
              x_addr    <= in_base + DADDR_W'(i_cnt + 6'd1);
              mac_first <= 1'b0;
              // Registered look-ahead: the next term is last when i+1 == fan_in-1.
              mac_last  <= (i_cnt + 6'd2 == fan_in);
            end
          end
        end

        S_ACT: begin
          if (act_ready) begin
            act_valid <= 1'b0;
            i_cnt     <= '0;
            if (j_cnt + 6'd1 < cur_nl) begin
              state     <= S_MAC;
              j_cnt     <= j_cnt + 6'd1;
              mac_valid <= 1'b1;
              x_addr    <= in_base;
              mac_first <= 1'b1;
              mac_last  <= (fan_in == 6'd1);
            end else if (6'(layer_idx) + 6'd1 < nlayers) begin
              // Next layer reads what this layer just wrote; its fan-in is cur_nl.
              state     <= S_MAC;
              layer_idx <= layer_idx + 3'd1;
              j_cnt     <= '0;
              in_base   <= out_base;
              out_base  <= out_base + DADDR_W'(cur_nl);
              mac_valid <= 1'b1;
              x_addr    <= out_base;
              mac_first <= 1'b1;
              mac_last  <= (cur_nl == 6'd1);
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench for nn_layer_sequencer: expected command streams come
// from a loop-level model of the forward pass and are compared transfer by
// transfer, with stall-stability and mutual-exclusion checks on every cycle.
module tb_nn_layer_sequencer;
  localparam int N_IN = 2;
  localparam int WW   = 15;
  localparam int DW   = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    no_layers = '0;
  logic [5:0]    nl_in [5];
  logic [1:0]    af_in [5];
  logic          mac_ready = 1'b1;
  logic          act_ready = 1'b1;
  logic          busy, done, err, mac_valid, mac_first, mac_last, act_valid;
  logic [WW-1:0] w_addr;
  logic [DW-1:0] x_addr, y_addr;
  logic [1:0]    act_func;
  logic [2:0]    layer_idx;

  nn_layer_sequencer #(.N_INPUTS(N_IN), .WADDR_W(WW), .DADDR_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .no_layers(no_layers),
    .nl1(nl_in[0]), .nl2(nl_in[1]), .nl3(nl_in[2]), .nl4(nl_in[3]), .nl5(nl_in[4]),
    .afl1(af_in[0]), .afl2(af_in[1]), .afl3(af_in[2]), .afl4(af_in[3]), .afl5(af_in[4]),
    .busy(busy), .done(done), .err(err),
    .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_first(mac_first), .mac_last(mac_last),
    .w_addr(w_addr), .x_addr(x_addr),
    .act_valid(act_valid), .act_ready(act_ready), .act_func(act_func), .y_addr(y_addr),
    .layer_idx(layer_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_act;
    logic [WW-1:0] w;
    logic [DW-1:0] x;
    bit            first;
    bit            last;
    logic [DW-1:0] y;
    logic [1:0]    f;
    logic [2:0]    layer;
  } ev_t;

  ev_t           q[$];
  int            checks = 0;
  int            failures = 0;
  bit            mon_en = 1'b0;
  bit            rdy_rand = 1'b0;
  int            mac_cnt = 0;
  int            done_cnt = 0;
  logic [DW-1:0] last_y = '0;
  int            cyc;
  bit            got;

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Forward pass as nested loops: layer -> neuron -> weight, one flat weight stream.
  task automatic build_model(input int nlay);
    int  w, ib, ob, fan;
    ev_t ev;
    q.delete();
    w = 0; ib = 0; ob = N_IN;
    for (int L = 0; L < nlay; L++) begin
      if (L == 0) fan = N_IN;
      else        fan = int'(nl_in[L-1]);
      for (int j = 0; j < int'(nl_in[L]); j++) begin
        for (int i = 0; i < fan; i++) begin
          ev = '{is_act: 1'b0, w: WW'(w), x: DW'(ib + i), first: (i == 0),
                 last: (i == fan - 1), y: '0, f: '0, layer: 3'(L)};
          q.push_back(ev);
          w++;
        end
        ev = '{is_act: 1'b1, w: '0, x: '0, first: 1'b0, last: 1'b0,
               y: DW'(ob + j), f: af_in[L], layer: 3'(L)};
        q.push_back(ev);
      end
      ib = ob;
      ob = ob + int'(nl_in[L]);
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) begin
        mac_ready = 1'($urandom_range(0, 1));
        act_ready = 1'($urandom_range(0, 1));
      end else begin
        mac_ready = 1'b1;
        act_ready = 1'b1;
      end
    end
  endtask

  task automatic monitor_loop();
    bit            pm, pa;
    logic [63:0]   pmv, pav;
    ev_t           ev;
    pm = 1'b0; pa = 1'b0; pmv = '0; pav = '0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        pm = 1'b0;
        pa = 1'b0;
        continue;
      end
      chk("valid_exclusive", {mac_valid, act_valid}, (mac_valid && act_valid) ? 2'b10 : {mac_valid, act_valid});
      if (pm) chk("mac_stall_hold", {1'b1, mac_valid, w_addr, x_addr, mac_first, mac_last}, pmv);
      if (pa) chk("act_stall_hold", {1'b1, act_valid, y_addr, act_func, layer_idx}, pav);
      if (mac_valid && mac_ready) begin
        mac_cnt++;
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL mac_unexpected: got w=%0d x=%0d expected no transfer", w_addr, x_addr);
        end else begin
          ev = q.pop_front();
          chk("mac_xfer", {1'b0, w_addr, x_addr, mac_first, mac_last, layer_idx},
              {ev.is_act, ev.w, ev.x, ev.first, ev.last, ev.layer});
        end
      end
      if (act_valid && act_ready) begin
        last_y = y_addr;
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL act_unexpected: got y=%0d expected no transfer", y_addr);
        end else begin
          ev = q.pop_front();
          chk("act_xfer", {1'b1, y_addr, act_func, layer_idx}, {ev.is_act, ev.y, ev.f, ev.layer});
        end
      end
      if (done) done_cnt++;
      pm  = mac_valid && !mac_ready;
      pmv = {1'b1, 1'b1, w_addr, x_addr, mac_first, mac_last};
      pa  = act_valid && !act_ready;
      pav = {1'b1, 1'b1, y_addr, act_func, layer_idx};
    end
  endtask

  // One run from start to done. cycles counts the start cycle as 1 and the done cycle inclusive.
  task automatic run_cfg(input int nlay, input bit exp_err, input bit repulse,
                         input int budget, output int cycles);
    int m0, d0;
    bit seen;
    if (!exp_err) build_model(nlay);
    else          q.delete();
    m0 = mac_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    no_layers = 6'(nlay);
    start = 1'b1;
    cycles = 1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 2;
    seen = 1'b0;
    while (!seen && cycles <= budget) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cycles++;
        start = repulse && (cycles == 6 || cycles == 7);
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1'b1);
    chk("err_at_done", err, exp_err);
    @(posedge clk); #1;
    chk("busy_done_low_after", {busy, done}, 2'b00);
    chk("queue_drained", q.size(), 0);
    chk("done_pulse_count", done_cnt - d0, 1);
    chk("err_sticky_idle", err, exp_err);
    if (exp_err) chk("err_no_mac", mac_cnt - m0, 0);
  endtask

  task automatic set_cfg1();
    nl_in[0] = 6'd2; nl_in[1] = 6'd1; nl_in[2] = 6'd0; nl_in[3] = 6'd0; nl_in[4] = 6'd0;
    af_in[0] = 2'b01; af_in[1] = 2'b10; af_in[2] = 2'b00; af_in[3] = 2'b00; af_in[4] = 2'b00;
  endtask

  initial begin
    int nlay;
    set_cfg1();
    fork
      ready_driver();
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, err, mac_valid, mac_first, mac_last, w_addr, x_addr,
                          act_valid, act_func, y_addr, layer_idx}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Pin the model to the hand-derived 2-2-1 sequence
    build_model(2);
    chk("model_len", q.size(), 9);
    chk("model_neuron0", {q[0].w, q[0].x, q[0].first, q[1].w, q[1].x, q[1].last},
        {15'd0, 9'd0, 1'b1, 15'd1, 9'd1, 1'b1});
    chk("model_act0", {q[2].is_act, q[2].y, q[2].f}, {1'b1, 9'd2, 2'b01});
    chk("model_neuron1", {q[3].w, q[3].x, q[4].w, q[4].x, q[5].y, q[5].f},
        {15'd2, 9'd0, 15'd3, 9'd1, 9'd3, 2'b01});
    chk("model_layer2", {q[6].w, q[6].x, q[7].w, q[7].x, q[8].y, q[8].f},
        {15'd4, 9'd2, 15'd5, 9'd3, 9'd4, 2'b10});

    // Full sequence, ready tied high
    run_cfg(2, 1'b0, 1'b0, 100, cyc);
    chk("cycles_start_to_done", cyc, 12);

    // Same config with random back-pressure
    rdy_rand = 1'b1;
    run_cfg(2, 1'b0, 1'b0, 500, cyc);
    rdy_rand = 1'b0;

    // Configuration errors
    run_cfg(0, 1'b1, 1'b0, 50, cyc);
    chk("err0_done_latency", cyc, 3);
    run_cfg(6, 1'b1, 1'b0, 50, cyc);
    chk("err6_done_latency", cyc, 3);
    nl_in[0] = 6'd2; nl_in[1] = 6'd1; nl_in[2] = 6'd0;
    run_cfg(3, 1'b1, 1'b0, 50, cyc);
    chk("err_nl3_done_latency", cyc, 3);

    // Good run after error clears err; start re-pulsed while busy is ignored
    set_cfg1();
    run_cfg(2, 1'b0, 1'b1, 100, cyc);
    chk("repulse_cycles", cyc, 12);

    // Maximum network
    for (int k = 0; k < 5; k++) begin
      nl_in[k] = 6'd63;
      af_in[k] = 2'($urandom_range(0, 3));
    end
    begin
      int m0;
      m0 = mac_cnt;
      run_cfg(5, 1'b0, 1'b0, 20000, cyc);
      chk("max_mac_count", mac_cnt - m0, 16002);
      chk("max_final_y", last_y, 9'd316);
      chk("max_cycles", cyc, 16320);
    end

    // Asynchronous reset in the middle of layer 2
    set_cfg1();
    mon_en = 1'b0;
    q.delete();
    @(posedge clk); #1;
    no_layers = 6'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (layer_idx == 3'd1 && mac_valid) got = 1'b1;
    end
    chk("reached_layer2", got, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, done, err, mac_valid, mac_first, mac_last, w_addr, x_addr,
                                act_valid, act_func, y_addr, layer_idx}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    rdy_rand = 1'b1;
    run_cfg(2, 1'b0, 1'b0, 500, cyc);

    // Random configurations under random back-pressure
    for (int r = 0; r < 6; r++) begin
      nlay = int'($urandom_range(1, 5));
      for (int k = 0; k < 5; k++) begin
        nl_in[k] = 6'($urandom_range(1, 6));
        af_in[k] = 2'($urandom_range(0, 3));
      end
      run_cfg(nlay, 1'b0, 1'b0, 5000, cyc);
    end
    rdy_rand = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
